llc_input_arbiter_mc: RTL and testbench

- Parametrised, multi-channel LLC front-end decoder/arbiter. Each `decode_en` cycle it selects one of: a reset/flush sequence, one response, or one request out of `N_REQ_CH` request channels.
- Generates the ready handshakes and registers the selected operation plus its tag/set breakdown for the LLC main FSM.
- Differences from the single-channel decoder:
  - flush set/way counters are held internally;
  - round-robin arbitration across request channels;
  - set-conflict replay carries its own address;
  - flush-done is a held valid/ready handshake.

---
 rtl/llc_input_arbiter_mc.sv | 214 +++++++++++++++++++++
 tb/tb_llc_input_arbiter_mc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_input_arbiter_mc.sv
// LLC front-end decoder/arbiter: each enabled cycle selects a flush step, a
// response, a conflict replay or one of N request channels, and registers it.
module llc_input_arbiter_mc #(
  parameter int N_REQ_CH       = 2,
  parameter int LINE_ADDR_BITS = 26,
  parameter int SET_BITS       = 8,
  parameter int LLC_WAYS       = 16,
  parameter int N_MSHR         = 8,
  parameter int RR_EN          = 1,
  localparam int WAY_W = $clog2(LLC_WAYS),
  localparam int CNT_W = $clog2(N_MSHR + 1),
  localparam int CH_W  = (N_REQ_CH > 1) ? $clog2(N_REQ_CH) : 1,
  localparam int TAG_W = LINE_ADDR_BITS - SET_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               decode_en,
  input  logic                               rst_tb_valid,
  output logic                               rst_tb_ready,
  output logic                               rst_tb_done_valid,
  input  logic                               rst_tb_done_ready,
  input  logic                               rsp_valid,
  output logic                               rsp_ready,
  input  logic [LINE_ADDR_BITS-1:0]          rsp_addr,
  input  logic [N_REQ_CH-1:0]                req_valid,
  output logic [N_REQ_CH-1:0]                req_ready,
  input  logic [N_REQ_CH*LINE_ADDR_BITS-1:0] req_addr,
  input  logic                               set_conflict,
  input  logic [LINE_ADDR_BITS-1:0]          conflict_addr,
  input  logic [CNT_W-1:0]                   mshr_free_cnt,
  input  logic                               evict_stall,
  output logic                               do_get_rsp,
  output logic                               do_get_req,
  output logic                               do_flush,
  output logic                               req_from_conflict,
  output logic [CH_W-1:0]                    req_ch,
  output logic [TAG_W-1:0]                   line_tag,
  output logic [SET_BITS-1:0]                line_set,
  output logic [WAY_W-1:0]                   flush_way,
  output logic                               flush_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [SET_BITS-1:0]       set_cnt_r;
  logic [WAY_W-1:0]          way_cnt_r;
  logic [CH_W-1:0]           rr_ptr_r;
  logic [CH_W-1:0]           grant_ch_s;
  logic                      idle_s, last_step_s;
  logic                      take_rst_s, take_rsp_s, take_req_s, take_conf_s, take_fresh_s;
  logic [LINE_ADDR_BITS-1:0] fresh_addr_s, sel_addr_s;
  logic                      nxt_rsp_s, nxt_req_s, nxt_flush_s, nxt_conf_s;
  logic [CH_W-1:0]           nxt_ch_s;
  logic [TAG_W-1:0]          nxt_tag_s;
  logic [SET_BITS-1:0]       nxt_set_s;
  logic [WAY_W-1:0]          nxt_way_s;

  assign idle_s       = (state_r == ST_IDLE);
  assign last_step_s  = (set_cnt_r == {SET_BITS{1'b1}}) && (way_cnt_r == {WAY_W{1'b1}});
  assign take_rst_s   = decode_en && idle_s && rst_tb_valid;
  assign take_rsp_s   = decode_en && idle_s && !rst_tb_valid && rsp_valid &&
                        (mshr_free_cnt != CNT_W'(N_MSHR));
  assign take_req_s   = decode_en && idle_s && !rst_tb_valid && !take_rsp_s &&
                        (set_conflict || (|req_valid)) &&
                        (mshr_free_cnt != {CNT_W{1'b0}}) && !evict_stall;
  assign take_conf_s  = take_req_s && set_conflict;
  assign take_fresh_s = take_req_s && !set_conflict;
  assign fresh_addr_s = req_addr[grant_ch_s*LINE_ADDR_BITS +: LINE_ADDR_BITS];

  assign rst_tb_ready      = take_rst_s;
  assign rsp_ready         = take_rsp_s;
  assign rst_tb_done_valid = (state_r == ST_DONE);
  assign flush_busy        = (state_r != ST_IDLE);

  // Arbiter: nearest valid channel after the start point, wrapping around;
  // fixed priority is the same search anchored at the last channel.
  always_comb begin
    int start_v;
    int dist_v;
    int best_v;
    logic hit_v;
    start_v    = (RR_EN != 0) ? int'(rr_ptr_r) : (N_REQ_CH - 1);
    best_v     = N_REQ_CH;
    dist_v     = 0;
    hit_v      = 1'b0;
    grant_ch_s = {CH_W{1'b0}};
    for (int c = 0; c < N_REQ_CH; c++) begin
      dist_v     = c - start_v - 1;
      dist_v     = (dist_v < 0) ? (dist_v + N_REQ_CH) : dist_v;
      hit_v      = req_valid[c] && (dist_v < best_v);
      grant_ch_s = hit_v ? CH_W'(c) : grant_ch_s;
      best_v     = hit_v ? dist_v : best_v;
    end
  end

  // One-hot accept for the granted fresh request.
  always_comb begin
    req_ready = {N_REQ_CH{1'b0}};
    for (int c = 0; c < N_REQ_CH; c++) begin
      req_ready[c] = take_fresh_s && (grant_ch_s == CH_W'(c));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic; DONE handshake is independent of decode_en.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = take_rst_s ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_nxt_s = (decode_en && last_step_s) ? ST_DONE : ST_FLUSH;
      ST_DONE:  state_nxt_s = rst_tb_done_ready ? ST_IDLE : ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered operation outputs.
  always_comb begin
    nxt_rsp_s   = 1'b0;
    nxt_req_s   = 1'b0;
    nxt_flush_s = 1'b0;
    nxt_conf_s  = 1'b0;
    nxt_ch_s    = {CH_W{1'b0}};
    nxt_tag_s   = {TAG_W{1'b0}};
    nxt_set_s   = {SET_BITS{1'b0}};
    nxt_way_s   = {WAY_W{1'b0}};
    sel_addr_s  = {LINE_ADDR_BITS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (take_rsp_s) begin
          nxt_rsp_s  = 1'b1;
          sel_addr_s = rsp_addr;
        end else if (take_conf_s) begin
          nxt_req_s  = 1'b1;
          nxt_conf_s = 1'b1;
          sel_addr_s = conflict_addr;
        end else if (take_fresh_s) begin
          nxt_req_s  = 1'b1;
          nxt_ch_s   = grant_ch_s;
          sel_addr_s = fresh_addr_s;
        end else begin
          sel_addr_s = {LINE_ADDR_BITS{1'b0}};
        end
        nxt_tag_s = sel_addr_s[LINE_ADDR_BITS-1:SET_BITS];
        nxt_set_s = sel_addr_s[SET_BITS-1:0];
      end
      ST_FLUSH: begin
        nxt_flush_s = 1'b1;
        nxt_set_s   = set_cnt_r;
        nxt_way_s   = way_cnt_r;
      end
      ST_DONE: nxt_flush_s = 1'b0;
      default: nxt_flush_s = 1'b0;
    endcase
  end

  // Operation output registers, loaded only on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_get_rsp        <= 1'b0;
      do_get_req        <= 1'b0;
      do_flush          <= 1'b0;
      req_from_conflict <= 1'b0;
      req_ch            <= {CH_W{1'b0}};
      line_tag          <= {TAG_W{1'b0}};
      line_set          <= {SET_BITS{1'b0}};
      flush_way         <= {WAY_W{1'b0}};
    end else if (decode_en) begin
      do_get_rsp        <= nxt_rsp_s;
      do_get_req        <= nxt_req_s;
      do_flush          <= nxt_flush_s;
      req_from_conflict <= nxt_conf_s;
      req_ch            <= nxt_ch_s;
      line_tag          <= nxt_tag_s;
      line_set          <= nxt_set_s;
      flush_way         <= nxt_way_s;
    end
  end

  // Flush set/way walk: way is the inner loop, carries into set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_cnt_r <= {SET_BITS{1'b0}};
      way_cnt_r <= {WAY_W{1'b0}};
    end else if (take_rst_s) begin
      set_cnt_r <= {SET_BITS{1'b0}};
      way_cnt_r <= {WAY_W{1'b0}};
    end else if ((state_r == ST_FLUSH) && decode_en) begin
      way_cnt_r <= way_cnt_r + {{(WAY_W-1){1'b0}}, 1'b1};
      if (way_cnt_r == {WAY_W{1'b1}}) begin
        set_cnt_r <= set_cnt_r + {{(SET_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  // Round-robin pointer: starts at the last channel so channel 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= CH_W'(N_REQ_CH - 1);
    end else if (take_fresh_s && (RR_EN != 0)) begin
      rr_ptr_r <= grant_ch_s;
    end
  end

endmodule

// File: tb/tb_llc_input_arbiter_mc.sv
// Bench for llc_input_arbiter_mc: two instances (round-robin / 8 set bits and
// fixed priority / 2 set bits) share stimulus and are checked against a model.
module tb_llc_input_arbiter_mc;

  localparam int NCH  = 3;
  localparam int LAB  = 26;
  localparam int NM   = 8;
  localparam int WAYS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             decode_en, rst_tb_valid, rst_tb_done_ready, rsp_valid;
  logic [LAB-1:0]   rsp_addr, conflict_addr;
  logic [NCH-1:0]   req_valid;
  logic [NCH*LAB-1:0] req_addr;
  logic             set_conflict, evict_stall;
  logic [3:0]       mshr_free_cnt;

  logic       got_rst_rdy [2], got_done_vld [2], got_rsp_rdy [2], got_busy [2];
  logic [2:0] got_req_rdy [2];
  logic       got_rsp [2], got_req [2], got_flush [2], got_conf [2];
  logic [1:0] got_ch [2];
  logic [0:0] got_way [2];
  logic [17:0] tag_a;
  logic [7:0]  set_a;
  logic [23:0] tag_b;
  logic [1:0]  set_b;

  llc_input_arbiter_mc #(.N_REQ_CH(NCH), .LINE_ADDR_BITS(LAB), .SET_BITS(8),
    .LLC_WAYS(WAYS), .N_MSHR(NM), .RR_EN(1)) dut_a (
    .clk(clk), .rst(rst), .decode_en(decode_en),
    .rst_tb_valid(rst_tb_valid), .rst_tb_ready(got_rst_rdy[0]),
    .rst_tb_done_valid(got_done_vld[0]), .rst_tb_done_ready(rst_tb_done_ready),
    .rsp_valid(rsp_valid), .rsp_ready(got_rsp_rdy[0]), .rsp_addr(rsp_addr),
    .req_valid(req_valid), .req_ready(got_req_rdy[0]), .req_addr(req_addr),
    .set_conflict(set_conflict), .conflict_addr(conflict_addr),
    .mshr_free_cnt(mshr_free_cnt), .evict_stall(evict_stall),
    .do_get_rsp(got_rsp[0]), .do_get_req(got_req[0]), .do_flush(got_flush[0]),
    .req_from_conflict(got_conf[0]), .req_ch(got_ch[0]), .line_tag(tag_a),
    .line_set(set_a), .flush_way(got_way[0]), .flush_busy(got_busy[0]));

  llc_input_arbiter_mc #(.N_REQ_CH(NCH), .LINE_ADDR_BITS(LAB), .SET_BITS(2),
    .LLC_WAYS(WAYS), .N_MSHR(NM), .RR_EN(0)) dut_b (
    .clk(clk), .rst(rst), .decode_en(decode_en),
    .rst_tb_valid(rst_tb_valid), .rst_tb_ready(got_rst_rdy[1]),
    .rst_tb_done_valid(got_done_vld[1]), .rst_tb_done_ready(rst_tb_done_ready),
    .rsp_valid(rsp_valid), .rsp_ready(got_rsp_rdy[1]), .rsp_addr(rsp_addr),
    .req_valid(req_valid), .req_ready(got_req_rdy[1]), .req_addr(req_addr),
    .set_conflict(set_conflict), .conflict_addr(conflict_addr),
    .mshr_free_cnt(mshr_free_cnt), .evict_stall(evict_stall),
    .do_get_rsp(got_rsp[1]), .do_get_req(got_req[1]), .do_flush(got_flush[1]),
    .req_from_conflict(got_conf[1]), .req_ch(got_ch[1]), .line_tag(tag_b),
    .line_set(set_b), .flush_way(got_way[1]), .flush_busy(got_busy[1]));

  int vectors;
  int miscompares;

  // Reference model: flush progress as a step index, arbiter as "last winner".
  int m_busy [2], m_done [2], m_fidx [2], m_last [2];
  int e_rsp [2], e_req [2], e_flush [2], e_conf [2], e_ch [2], e_tag [2], e_set [2], e_way [2];

  function automatic int sb(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic int rr(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input longint exp);
    vectors++;
    if (got !== 64'(exp)) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int k);
    int c;
    for (int i = 1; i <= NCH; i++) begin
      c = (rr(k) != 0) ? (m_last[k] + i) % NCH : i - 1;
      if (((req_valid >> c) & 3'd1) != 3'd0) return c;
    end
    return 0;
  endfunction

  task automatic comb_exp(input int k, output int rstr, output int rspr, output int okr,
                          output int reqr, output int ch);
    int idle;
    int base;
    idle = (m_busy[k] == 0 && m_done[k] == 0) ? 1 : 0;
    base = (decode_en && idle != 0 && !rst_tb_valid) ? 1 : 0;
    rstr = (decode_en && idle != 0 && rst_tb_valid) ? 1 : 0;
    rspr = (base != 0 && rsp_valid && mshr_free_cnt != NM) ? 1 : 0;
    okr  = (base != 0 && rspr == 0 && (set_conflict || req_valid != 0) &&
            mshr_free_cnt != 0 && !evict_stall) ? 1 : 0;
    ch   = pick(k);
    reqr = (okr != 0 && !set_conflict) ? (1 << ch) : 0;
  endtask

  task automatic clear_exp(input int k);
    e_rsp[k] = 0; e_req[k] = 0; e_flush[k] = 0; e_conf[k] = 0;
    e_ch[k] = 0; e_tag[k] = 0; e_set[k] = 0; e_way[k] = 0;
  endtask

  task automatic split(input int k, input longint a);
    e_tag[k] = int'(a >> sb(k));
    e_set[k] = int'(a & ((64'd1 << sb(k)) - 1));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_fidx[k] = 0; m_last[k] = NCH - 1;
      clear_exp(k);
    end
  endtask

  task automatic model_step();
    int rstr, rspr, okr, reqr, ch, pd;
    for (int k = 0; k < 2; k++) begin
      comb_exp(k, rstr, rspr, okr, reqr, ch);
      pd = m_done[k];
      if (decode_en) begin
        if (m_busy[k] == 0 && m_done[k] == 0) begin
          clear_exp(k);
          if (rstr != 0) begin
            m_busy[k] = 1;
            m_fidx[k] = 0;
          end else if (rspr != 0) begin
            e_rsp[k] = 1;
            split(k, 64'(rsp_addr));
          end else if (okr != 0) begin
            e_req[k] = 1;
            if (set_conflict) begin
              e_conf[k] = 1;
              split(k, 64'(conflict_addr));
            end else begin
              e_ch[k] = ch;
              split(k, 64'((req_addr >> (ch * LAB)) & 78'h3FF_FFFF));
              if (rr(k) != 0) m_last[k] = ch;
            end
          end
        end else if (m_busy[k] != 0) begin
          clear_exp(k);
          e_flush[k] = 1;
          e_set[k]   = m_fidx[k] / WAYS;
          e_way[k]   = m_fidx[k] % WAYS;
          m_fidx[k]++;
          if (m_fidx[k] == (1 << sb(k)) * WAYS) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_fidx[k] = 0;
          end
        end else begin
          clear_exp(k);
        end
      end
      if (pd != 0 && rst_tb_done_ready) m_done[k] = 0;
    end
  endtask

  task automatic check_comb();
    int rstr, rspr, okr, reqr, ch;
    for (int k = 0; k < 2; k++) begin
      comb_exp(k, rstr, rspr, okr, reqr, ch);
      check($sformatf("rst_tb_ready[%0d]", k), 64'(got_rst_rdy[k]), rstr);
      check($sformatf("rsp_ready[%0d]", k), 64'(got_rsp_rdy[k]), rspr);
      check($sformatf("req_ready[%0d]", k), 64'(got_req_rdy[k]), reqr);
      check($sformatf("done_valid[%0d]", k), 64'(got_done_vld[k]), m_done[k]);
      check($sformatf("flush_busy[%0d]", k), 64'(got_busy[k]),
            (m_busy[k] != 0 || m_done[k] != 0) ? 1 : 0);
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("do_get_rsp[%0d]", k), 64'(got_rsp[k]), e_rsp[k]);
      check($sformatf("do_get_req[%0d]", k), 64'(got_req[k]), e_req[k]);
      check($sformatf("do_flush[%0d]", k), 64'(got_flush[k]), e_flush[k]);
      check($sformatf("from_conflict[%0d]", k), 64'(got_conf[k]), e_conf[k]);
      check($sformatf("req_ch[%0d]", k), 64'(got_ch[k]), e_ch[k]);
      check($sformatf("flush_way[%0d]", k), 64'(got_way[k]), e_way[k]);
      check($sformatf("line_tag[%0d]", k), (k == 0) ? 64'(tag_a) : 64'(tag_b), e_tag[k]);
      check($sformatf("line_set[%0d]", k), (k == 0) ? 64'(set_a) : 64'(set_b), e_set[k]);
    end
  endtask

  // One clock: readies checked before the edge, registers just after it.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    decode_en = 1'b1; rst_tb_valid = 1'b0; rst_tb_done_ready = 1'b0;
    rsp_valid = 1'b0; rsp_addr = '0; req_valid = '0; req_addr = '0;
    set_conflict = 1'b0; conflict_addr = '0; mshr_free_cnt = 4'd8; evict_stall = 1'b0;
  endtask

  task automatic rand_inputs();
    decode_en         = ($urandom_range(0, 9) < 8);
    rst_tb_valid      = ($urandom_range(0, 399) == 0);
    rst_tb_done_ready = 1'($urandom_range(0, 1));
    rsp_valid         = 1'($urandom_range(0, 1));
    rsp_addr          = LAB'($urandom);
    req_valid         = NCH'($urandom);
    req_addr          = (NCH*LAB)'({$urandom, $urandom, $urandom});
    set_conflict      = ($urandom_range(0, 4) == 0);
    conflict_addr     = LAB'($urandom);
    mshr_free_cnt     = 4'($urandom_range(0, 8));
    evict_stall       = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    int rr_seq [4];
    rr_seq      = '{0, 1, 0, 1};
    vectors     = 0;
    miscompares = 0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_comb();
    check_regs();
    rst = 1'b1;

    // round-robin vs fixed priority
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_ch_a", 64'(got_ch[0]), rr_seq[i]);
      check("fixed_ch_b", 64'(got_ch[1]), 0);
    end

    // response beats requests; full-free MSHR hands the slot to a request
    rsp_valid = 1'b1; mshr_free_cnt = 4'd3;
    #1;
    check("prio_rsp_ready", 64'(got_rsp_rdy[0]), 1);
    check("prio_req_ready", 64'(got_req_rdy[0]), 0);
    tick();
    check("prio_do_rsp", 64'(got_rsp[0]), 1);
    mshr_free_cnt = 4'd8;
    tick();
    check("prio_do_req", 64'(got_req[0]), 1);

    // conflict replay
    rsp_valid = 1'b0; set_conflict = 1'b1; conflict_addr = 26'h00001A5;
    req_valid = 3'b001; mshr_free_cnt = 4'd5;
    #1;
    check("conf_req_ready", 64'(got_req_rdy[0]), 0);
    tick();
    check("conf_flag", 64'(got_conf[0]), 1);
    check("conf_set", 64'(set_a), 64'hA5);
    check("conf_tag", 64'(tag_a), 1);

    // gating and hold
    set_conflict = 1'b0; mshr_free_cnt = 4'd0;
    tick();
    check("gate_mshr", 64'(got_req[0]), 0);
    mshr_free_cnt = 4'd4; evict_stall = 1'b1;
    tick();
    check("gate_evict", 64'(got_req[0]), 0);
    evict_stall = 1'b0; req_valid = 3'b100;
    tick();
    decode_en = 1'b0; req_valid = 3'b001;
    tick();
    check("hold_req", 64'(got_req[1]), 1);
    check("hold_ch", 64'(got_ch[1]), 2);

    // full flush on the small instance
    set_idle();
    rst_tb_valid = 1'b1;
    tick();
    rst_tb_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("flush_step", 64'(got_flush[1]), 1);
      check("flush_set", 64'(set_b), i / 2);
      check("flush_way", 64'(got_way[1]), i % 2);
    end
    tick();
    check("flush_end", 64'(got_flush[1]), 0);
    check("done_valid", 64'(got_done_vld[1]), 1);
    rst_tb_done_ready = 1'b1;
    tick();
    check("done_busy", 64'(got_busy[1]), 0);
    repeat (520) tick();

    // reset in the middle of a flush
    rst_tb_valid = 1'b1;
    tick();
    rst_tb_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_busy", 64'(got_busy[1]), 0);
    check("abort_done", 64'(got_done_vld[1]), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 64'(got_done_vld[1]), 0);
    rst_tb_valid = 1'b1;
    tick();
    rst_tb_valid = 1'b0;
    tick();
    check("restart_set", 64'(set_b), 0);
    check("restart_way", 64'(got_way[1]), 0);
    check("restart_flush", 64'(got_flush[1]), 1);
    repeat (520) tick();

    // randomized traffic
    repeat (4000) begin
      rand_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
